xbus_arbiter: RTL and testbench

XBUS_ARBITER -- requirements
Module: xbus_arbiter

---
 rtl/xbus_arb_pkg.sv | 15 +
 rtl/xbus_arbiter_if.sv | 34 +++
 rtl/xbus_rr_pick.sv | 37 +++
 rtl/xbus_arbiter.sv | 136 +++++++++++++
 tb/tb_xbus_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/xbus_arb_pkg.sv
// Shared definitions for the Xbus DMA arbiter: FSM state encodings,
// default parameter values and the owner index width.
package xbus_arb_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam logic [7:0]  TIMEOUT_DEF = 8'd255;
  localparam int unsigned OWNER_W     = 3;
  localparam int unsigned CNT_W       = 8;

  // FSM state encodings
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

endpackage

// File: rtl/xbus_arbiter_if.sv
// Xbus arbitration bundle between the DMA masters and the arbiter.
//   busreq      : per-master level request (master -> arbiter)
//   ackin       : slave acknowledge (master side -> arbiter)
//   err_clr     : pulse clearing timeout_err (master side -> arbiter)
//   busgrant    : one-hot-or-zero grant (arbiter -> masters)
//   owner       : index of current or last owner
//   busy        : any grant active
//   timeout_err : sticky timeout flag
// modport master: requester side; modport slave: arbiter side.
interface xbus_arbiter_if
  import xbus_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
);

  logic [NREQ-1:0]    busreq;
  logic               ackin;
  logic               err_clr;
  logic [NREQ-1:0]    busgrant;
  logic [OWNER_W-1:0] owner;
  logic               busy;
  logic               timeout_err;

  modport master (
    output busreq, ackin, err_clr,
    input  busgrant, owner, busy, timeout_err
  );

  modport slave (
    input  busreq, ackin, err_clr,
    output busgrant, owner, busy, timeout_err
  );

endinterface

// File: rtl/xbus_rr_pick.sv
// Combinational round-robin picker: scans req starting at last_i+1
// (mod NREQ) and returns the first requester found.
//   req_i    : request vector
//   last_i   : index of the last owner
//   valid_o  : any request present
//   winner_o : index of the selected master
module xbus_rr_pick
  import xbus_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]    req_i,
  input  logic [OWNER_W-1:0] last_i,
  output logic               valid_o,
  output logic [OWNER_W-1:0] winner_o
);

  logic [7:0]         req_pad;
  logic [OWNER_W-1:0] cand;

  assign req_pad = 8'(req_i);

  // Offsets 1..NREQ visit every index once, ending on last_i itself.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OWNER_W'((32'(last_i) + k) % NREQ);
      if (!valid_o && req_pad[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/xbus_arbiter.sv
// Xbus DMA bus arbiter: round-robin grant of one master at a time with a
// one-cycle dead period (RELEASE) between owners. Optional grant timeout
// enabled by defining XBUS_ARB_TIMEOUT_EN.
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : xbus_arbiter_if.slave (busreq/ackin/err_clr in,
//           busgrant/owner/busy/timeout_err out)
module xbus_arbiter
  import xbus_arb_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter logic [7:0]  TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  xbus_arbiter_if.slave bus
);

  logic [1:0]         state_q, state_d;
  logic [NREQ-1:0]    busgrant_q, busgrant_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [OWNER_W-1:0] pick_winner;
  logic [7:0]         req_pad;
  logic [7:0]         grant_pad;
  logic               timeout_c;
  logic               enter_grant_c;

  assign req_pad       = 8'(bus.busreq);
  assign grant_pad     = 8'd1 << pick_winner;
  assign enter_grant_c = (state_q == IDLE) && pick_valid;

  xbus_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (bus.busreq),
    .last_i   (owner_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busgrant_q <= '0;
      owner_q    <= OWNER_W'(NREQ - 1);
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busgrant_q <= busgrant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    busgrant_d = busgrant_q;
    owner_d    = owner_q;
    case (state_q)
      IDLE: begin
        busgrant_d = '0;
        if (pick_valid) begin
          state_d    = GRANT;
          busgrant_d = grant_pad[NREQ-1:0];
          owner_d    = pick_winner;
        end
      end
      GRANT: begin
        if (!req_pad[owner_q] || timeout_c) begin
          state_d    = RELEASE;
          busgrant_d = '0;
        end
      end
      RELEASE: begin
        state_d    = IDLE;
        busgrant_d = '0;
      end
      default: begin
        state_d    = IDLE;
        busgrant_d = '0;
      end
    endcase
    busy_d = |busgrant_d;
  end

`ifdef XBUS_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  assign timeout_c = (state_q == GRANT) && (cnt_q == TIMEOUT);

  // Hold-time counter and sticky error flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Counter restarts on a new grant or an ackin, otherwise counts GRANT cycles
  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    if (enter_grant_c || bus.ackin) begin
      cnt_d = '0;
    end else if (state_q == GRANT) begin
      cnt_d = CNT_W'(cnt_q + 8'd1);
    end
    // A coinciding timeout takes priority over the clear
    if (timeout_c) begin
      timeout_err_d = 1'b1;
    end else if (bus.err_clr) begin
      timeout_err_d = 1'b0;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic unused_c;

  assign timeout_c       = 1'b0;
  assign unused_c        = ^{bus.ackin, bus.err_clr, TIMEOUT, enter_grant_c};
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.busgrant = busgrant_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Bench for xbus_arbiter: directed scenarios plus randomized traffic, all
// compared against a transaction-level reference model (who holds the bus,
// whether a dead cycle is pending, who owned it last). Honours
// XBUS_ARB_TIMEOUT_EN to select the expected timeout behaviour.
module tb_xbus_arbiter;
  import xbus_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam logic [7:0]  TO = 8'd10;
`ifdef XBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  xbus_arbiter_if #(.NREQ(N)) bus_if ();

  xbus_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int m_holder;   // -1 when nobody holds the bus
  int m_owner;
  int m_cnt;      // GRANT cycles since grant or last ackin
  bit m_dead;     // one idle cycle must follow every release
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_holder = -1;
    m_owner  = N - 1;
    m_cnt    = 0;
    m_dead   = 1'b0;
    m_err    = 1'b0;
  endfunction

  // Advance the model by one clock with the inputs present at that edge.
  function automatic void model_step(input logic [3:0] r, input logic a, input logic c);
    bit to;
    bit found;
    int i;
    to    = TO_EN && (m_holder >= 0) && (m_cnt == int'(TO));
    found = 1'b0;
    if (m_holder >= 0) begin
      if (!r[2'(m_holder)] || to) begin
        m_holder = -1;
        m_dead   = 1'b1;
      end else begin
        m_cnt = a ? 0 : m_cnt + 1;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else begin
      for (int k = 1; k <= int'(N); k++) begin
        i = (m_owner + k) % int'(N);
        if (!found && r[2'(i)]) begin
          found    = 1'b1;
          m_holder = i;
          m_owner  = i;
          m_cnt    = 0;
        end
      end
    end
    if (TO_EN) begin
      if (to) m_err = 1'b1;
      else if (c) m_err = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_holder >= 0) ? 4'(1 << m_holder) : 4'd0;
    check_eq({tag, ".grant"}, 32'(bus_if.busgrant), 32'(eg));
    check_eq({tag, ".busy"},  32'(bus_if.busy),     32'(m_holder >= 0));
    check_eq({tag, ".owner"}, 32'(bus_if.owner),    32'(m_owner));
    check_eq({tag, ".err"},   32'(bus_if.timeout_err), 32'(m_err));
  endtask

  // Drive one cycle of inputs at the negedge, check at the next negedge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic a, input logic c);
    bus_if.busreq  = r;
    bus_if.ackin   = a;
    bus_if.err_clr = c;
    model_step(r, a, c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    bus_if.busreq  = '0;
    bus_if.ackin   = 1'b0;
    bus_if.err_clr = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    check_eq("rst.owner_const", 32'(bus_if.owner), 32'(N - 1));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int order[$];
    int guard;
    logic [3:0] r;
    logic [3:0] cur;

    reset = 1'b1;
    bus_if.busreq  = '0;
    bus_if.ackin   = 1'b0;
    bus_if.err_clr = 1'b0;

    // Single request
    do_reset();
    for (int i = 0; i < 4; i++) cyc("single.idle", 4'b0000, 1'b0, 1'b0);
    cyc("single.req", 4'b0100, 1'b0, 1'b0);
    check_eq("single.grant_const", 32'(bus_if.busgrant), 32'h4);
    check_eq("single.owner_const", 32'(bus_if.owner), 32'd2);
    for (int i = 0; i < 13; i++) cyc("single.hold", 4'b0100, 1'b1, 1'b0);
    cyc("single.drop", 4'b0000, 1'b0, 1'b0);
    check_eq("single.release_const", 32'(bus_if.busgrant), 32'h0);
    cyc("single.idle2", 4'b0000, 1'b0, 1'b0);

    // Rotation with all masters requesting
    do_reset();
    for (int g = 0; g < 5; g++) begin
      guard = 0;
      cyc("rot.req", 4'b1111, 1'b1, 1'b0);
      while (bus_if.busgrant == '0 && guard < 6) begin
        cyc("rot.wait", 4'b1111, 1'b1, 1'b0);
        guard++;
      end
      check_eq("rot.wait_bound", 32'(guard < 6), 32'd1);
      order.push_back(int'(bus_if.owner));
      cyc("rot.hold", 4'b1111, 1'b1, 1'b0);
      cur = 4'b1111;
      cur[bus_if.owner[1:0]] = 1'b0;
      cyc("rot.drop", cur, 1'b1, 1'b0);
    end
    for (int g = 0; g < 5; g++)
      check_eq("rot.order", 32'(order[g]), 32'(g % 4));

    // Wrap and skip
    do_reset();
    cyc("wrap.req", 4'b0110, 1'b0, 1'b0);
    check_eq("wrap.grant1", 32'(bus_if.busgrant), 32'h2);
    cyc("wrap.hold", 4'b0110, 1'b1, 1'b0);
    cyc("wrap.drop1", 4'b0100, 1'b0, 1'b0);
    cyc("wrap.rel", 4'b0011, 1'b0, 1'b0);
    cyc("wrap.idle", 4'b0011, 1'b0, 1'b0);
    check_eq("wrap.grant0", 32'(bus_if.busgrant), 32'h1);
    cyc("wrap.drop0", 4'b0010, 1'b0, 1'b0);
    cyc("wrap.rel2", 4'b0010, 1'b0, 1'b0);
    cyc("wrap.idle2", 4'b0010, 1'b0, 1'b0);
    check_eq("wrap.grant1b", 32'(bus_if.busgrant), 32'h2);
    cyc("wrap.drop1b", 4'b0000, 1'b0, 1'b0);
    cyc("wrap.rel3", 4'b0010, 1'b0, 1'b0);
    cyc("wrap.idle3", 4'b0010, 1'b0, 1'b0);
    check_eq("wrap.regrant1", 32'(bus_if.busgrant), 32'h2);

    // Grant hold without ackin: timeout when enabled, indefinite otherwise
    do_reset();
    cyc("to.req", 4'b0100, 1'b0, 1'b0);
    if (TO_EN) begin
      for (int i = 0; i < 10; i++) begin
        cyc("to.hold", 4'b0100, 1'b0, 1'b0);
        check_eq("to.held_const", 32'(bus_if.busgrant), 32'h4);
      end
      cyc("to.fire", 4'b0100, 1'b0, 1'b0);
      check_eq("to.grant_off", 32'(bus_if.busgrant), 32'h0);
      check_eq("to.err_set", 32'(bus_if.timeout_err), 32'd1);
      cyc("to.clr", 4'b0000, 1'b0, 1'b1);
      check_eq("to.err_clr", 32'(bus_if.timeout_err), 32'd0);
      cyc("to.idle", 4'b0000, 1'b0, 1'b0);
      cyc("to.req2", 4'b0100, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) cyc("to.ack", 4'b0100, (i % 5) == 4, 1'b0);
      check_eq("to.ack_held", 32'(bus_if.busgrant), 32'h4);
      check_eq("to.ack_noerr", 32'(bus_if.timeout_err), 32'd0);
      cyc("to.ack_last", 4'b0100, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc("to.hold2", 4'b0100, 1'b0, 1'b0);
      cyc("to.setwins", 4'b0100, 1'b0, 1'b1);
      check_eq("to.setwins_const", 32'(bus_if.timeout_err), 32'd1);
      cyc("to.drop", 4'b0000, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < 1000; i++) cyc("noto.hold", 4'b0100, 1'b0, (i % 97) == 3);
      check_eq("noto.held_const", 32'(bus_if.busgrant), 32'h4);
      check_eq("noto.err_const", 32'(bus_if.timeout_err), 32'd0);
      cyc("noto.drop", 4'b0000, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-grant
    do_reset();
    cyc("areset.req", 4'b0001, 1'b0, 1'b0);
    check_eq("areset.grant_const", 32'(bus_if.busgrant), 32'h1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all("areset.mid");
    check_eq("areset.grant_off", 32'(bus_if.busgrant), 32'h0);
    check_eq("areset.owner", 32'(bus_if.owner), 32'd3);
    #1 reset = 1'b0;
    model_step(4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    check_all("areset.regrant");
    check_eq("areset.regrant_const", 32'(bus_if.busgrant), 32'h1);

    // Randomized traffic with sticky requests
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      cyc("rand", r, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
